// File: rtl/mem_access_if.sv
// Bus bundle for mem_access_unit: fetch port, data port and the single-port memory side.
// The unit connects through the slave modport; the requesters/memory environment use master.
interface mem_access_if;
    logic        if_req;
    logic [5:0]  if_addr;
    logic        if_ready;
    logic        if_fault;
    logic [31:0] if_data;

    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_func3;
    logic [5:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic        dm_err;
    logic [31:0] dm_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_fault, if_data, dm_ready, dm_err, dm_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_fault, if_data, dm_ready, dm_err, dm_rdata,
               mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Arbitrates fetch and data requests onto a single-port memory with alignment/legality checks.
// Define COMPRESSED_FETCH_EN to allow halfword-aligned fetches (16-bit compressed instructions).
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [1:0]  starve_cnt;
    logic        sel_fetch;
    logic        lat_we;
    logic [2:0]  lat_func3;
    logic [5:0]  lat_addr;
    logic [31:0] lat_wdata;

    logic        fetch_ok;
    logic        grant_any;
    logic        grant_fetch;
    logic        g_we;
    logic        g_ok;
    logic [2:0]  g_func3;
    logic [5:0]  g_addr;
    logic [31:0] g_wdata;

    function automatic logic data_legal(input logic we, input logic [2:0] f3, input logic [5:0] a);
        logic size_ok;
        logic align_ok;
        if (we)
            size_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            size_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   align_ok = ~a[0];
            2'b10:   align_ok = (a[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return size_ok && align_ok;
    endfunction

`ifdef COMPRESSED_FETCH_EN
    assign fetch_ok = ~bus.if_addr[0];
`else
    assign fetch_ok = (bus.if_addr[1:0] == 2'b00);
`endif

    // Fetch wins only after the data port has taken two grants in a row over it.
    always_comb begin
        grant_any   = bus.if_req | bus.dm_req;
        grant_fetch = bus.if_req & (~bus.dm_req | (starve_cnt == 2'd2));
        g_we        = grant_fetch ? 1'b0     : bus.dm_we;
        g_func3     = grant_fetch ? 3'b010   : bus.dm_func3;
        g_addr      = grant_fetch ? bus.if_addr : bus.dm_addr;
        g_wdata     = grant_fetch ? 32'h0    : bus.dm_wdata;
        g_ok        = grant_fetch ? fetch_ok : data_legal(bus.dm_we, bus.dm_func3, bus.dm_addr);
    end

    assign bus.mem_addr  = (state == ACCESS) ? lat_addr  : 6'h0;
    assign bus.mem_func3 = (state == ACCESS) ? lat_func3 : 3'h0;
    assign bus.mem_wdata = bus.mem_write     ? lat_wdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= 2'd0;
            sel_fetch     <= 1'b0;
            lat_we        <= 1'b0;
            lat_func3     <= 3'h0;
            lat_addr      <= 6'h0;
            lat_wdata     <= 32'h0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.if_ready  <= 1'b0;
            bus.if_fault  <= 1'b0;
            bus.if_data   <= 32'h0;
            bus.dm_ready  <= 1'b0;
            bus.dm_err    <= 1'b0;
            bus.dm_rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.if_req)
                        starve_cnt <= 2'd0;
                    else if (grant_fetch)
                        starve_cnt <= 2'd0;
                    else if (starve_cnt != 2'd2)
                        starve_cnt <= starve_cnt + 2'd1;
                    if (grant_any) begin
                        sel_fetch <= grant_fetch;
                        lat_we    <= g_we;
                        lat_func3 <= g_func3;
                        lat_addr  <= g_addr;
                        lat_wdata <= g_wdata;
                        if (g_ok) begin
                            state         <= ACCESS;
                            bus.mem_read  <= ~g_we;
                            bus.mem_write <= g_we;
                        end else begin
                            state <= RESP;
                            if (grant_fetch) begin
                                bus.if_ready <= 1'b1;
                                bus.if_fault <= 1'b1;
                            end else begin
                                bus.dm_ready <= 1'b1;
                                bus.dm_err   <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    state         <= RESP;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    if (sel_fetch) begin
                        bus.if_ready <= 1'b1;
                        bus.if_data  <= bus.mem_rdata;
                    end else begin
                        bus.dm_ready <= 1'b1;
                        bus.dm_rdata <= lat_we ? 32'h0 : bus.mem_rdata;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    bus.if_ready <= 1'b0;
                    bus.if_fault <= 1'b0;
                    bus.if_data  <= 32'h0;
                    bus.dm_ready <= 1'b0;
                    bus.dm_err   <= 1'b0;
                    bus.dm_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: memory model, directed scenarios and random single accesses.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

`ifdef COMPRESSED_FETCH_EN
    localparam int FETCH_ALIGN = 2;
`else
    localparam int FETCH_ALIGN = 4;
`endif

    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem_arr [64];

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'h0380_2403;
        if (i == 56) return 32'd52;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Memory environment: contents reload on every reset edge, writes land on the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
        end else if (bus.mem_write) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always_comb bus.mem_rdata = mem_arr[bus.mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = 6'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_func3 = 3'h0;
        bus.dm_addr  = 6'h0;
        bus.dm_wdata = 32'h0;
    endtask

    // One isolated access; expectations derived from legality/size arithmetic.
    task automatic do_single(input bit fetch, input bit we, input logic [2:0] f3,
                             input logic [5:0] addr, input logic [31:0] wdata, input string tag);
        bit          load_ok [8] = '{1, 1, 1, 0, 1, 1, 0, 0};
        bit          legal;
        int          size;
        logic [31:0] exp_data;
        int          rd_n = 0;
        int          wr_n = 0;
        int          lat = 0;
        logic [5:0]  s_addr = '0;
        logic [2:0]  s_f3 = '0;
        logic [31:0] s_wd = '0;
        bit          wd_leak = 0;
        bit          got_if = 0;
        bit          got_dm = 0;
        bit          got_flt = 0;
        bit          other_flt = 0;
        logic [31:0] got_data = '0;

        if (fetch) begin
            legal = (int'(addr) % FETCH_ALIGN) == 0;
        end else begin
            size  = 1 << (int'(f3) % 4);
            legal = (we ? (f3 < 3'd3) : load_ok[f3]) && ((int'(addr) % size) == 0);
        end
        exp_data = (legal && (fetch || !we)) ? mem_arr[addr] : 32'h0;

        if (fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = we;
            bus.dm_func3 = f3;
            bus.dm_addr  = addr;
            bus.dm_wdata = wdata;
        end

        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.mem_read) begin
                rd_n++;
                s_addr = bus.mem_addr;
                s_f3   = bus.mem_func3;
            end
            if (bus.mem_write) begin
                wr_n++;
                s_addr = bus.mem_addr;
                s_f3   = bus.mem_func3;
                s_wd   = bus.mem_wdata;
            end else if (bus.mem_wdata !== 32'h0) begin
                wd_leak = 1'b1;
            end
            if (bus.if_ready || bus.dm_ready) begin
                lat       = c;
                got_if    = bus.if_ready;
                got_dm    = bus.dm_ready;
                got_flt   = fetch ? bus.if_fault : bus.dm_err;
                other_flt = fetch ? bus.dm_err   : bus.if_fault;
                got_data  = fetch ? bus.if_data  : bus.dm_rdata;
                break;
            end
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;

        check({tag, "_latency"}, 32'(lat), legal ? 32'd2 : 32'd1);
        check({tag, "_ready_sel"}, 32'({got_if, got_dm}), fetch ? 32'd2 : 32'd1);
        check({tag, "_fault"}, 32'({got_flt, other_flt}), legal ? 32'd0 : 32'd2);
        check({tag, "_data"}, got_data, exp_data);
        check({tag, "_reads"}, 32'(rd_n), (legal && (fetch || !we)) ? 32'd1 : 32'd0);
        check({tag, "_writes"}, 32'(wr_n), (legal && !fetch && we) ? 32'd1 : 32'd0);
        check({tag, "_wdata_leak"}, 32'(wd_leak), 32'd0);
        if (legal) begin
            check({tag, "_mem_addr"}, 32'(s_addr), 32'(addr));
            check({tag, "_mem_func3"}, 32'(s_f3), fetch ? 32'd2 : 32'(f3));
            if (!fetch && we) check({tag, "_mem_wdata"}, s_wd, wdata);
        end

        tick();
        check({tag, "_quiet"},
              32'({bus.if_ready, bus.dm_ready, bus.if_fault, bus.dm_err}) | bus.if_data | bus.dm_rdata,
              32'h0);
    endtask

    // One fetch competing with n_dm back-to-back word accesses from the data port.
    task automatic run_mix(input int n_dm, input bit we, input logic [5:0] d_addr,
                           input logic [5:0] f_addr, input string tag);
        int          exp_order [$];
        int          got_order [$];
        int          got_cyc [$];
        int          starve = 0;
        int          left = n_dm;
        bit          fpend = 1;
        int          wr_n = 0;
        int          dm_done = 0;
        bit          prev_wr = 0;
        bit          dbl_wr = 0;
        logic [31:0] f_exp;
        logic [31:0] d_exp;

        // Data is preferred until it has been granted twice while fetch waited.
        while (left > 0 || fpend) begin
            if (fpend && (left == 0 || starve == 2)) begin
                exp_order.push_back(1);
                fpend  = 0;
                starve = 0;
            end else begin
                exp_order.push_back(0);
                left--;
                if (fpend && starve < 2) starve++;
            end
        end

        f_exp = mem_arr[f_addr];
        d_exp = mem_arr[d_addr];
        bus.if_req   = 1'b1;
        bus.if_addr  = f_addr;
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_func3 = 3'b010;
        bus.dm_addr  = d_addr;
        bus.dm_wdata = $urandom;

        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bus.mem_write) begin
                wr_n++;
                if (prev_wr) dbl_wr = 1'b1;
                check({tag, "_store_wdata"}, bus.mem_wdata, bus.dm_wdata);
            end
            prev_wr = bus.mem_write;
            if (bus.dm_ready) begin
                got_order.push_back(0);
                got_cyc.push_back(c);
                if (!we) check({tag, "_load_data"}, bus.dm_rdata, d_exp);
                dm_done++;
                if (dm_done == n_dm) bus.dm_req = 1'b0;
                else bus.dm_wdata = $urandom;
            end
            if (bus.if_ready) begin
                got_order.push_back(1);
                got_cyc.push_back(c);
                check({tag, "_fetch_data"}, bus.if_data, f_exp);
                bus.if_req = 1'b0;
            end
            if (got_order.size() == n_dm + 1) break;
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();

        check({tag, "_events"}, 32'(got_order.size()), 32'(exp_order.size()));
        for (int k = 0; k < exp_order.size(); k++) begin
            check({tag, "_order"}, (k < got_order.size()) ? 32'(got_order[k]) : 32'hFFFF_FFFF,
                  32'(exp_order[k]));
            check({tag, "_cycle"}, (k < got_cyc.size()) ? 32'(got_cyc[k]) : 32'hFFFF_FFFF,
                  32'(2 + 3 * k));
        end
        check({tag, "_writes"}, 32'(wr_n), we ? 32'(n_dm) : 32'd0);
        check({tag, "_write_one_cycle"}, 32'(dbl_wr), 32'd0);
    endtask

    initial begin
        logic [5:0]  a;
        logic [5:0]  fa;
        logic [31:0] wd;

        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        check("reset_strobes", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        check("reset_handshake", 32'({bus.if_ready, bus.if_fault, bus.dm_ready, bus.dm_err}), 32'h0);
        check("reset_data", bus.if_data | bus.dm_rdata | bus.mem_wdata, 32'h0);
        check("reset_mem_addr", 32'({bus.mem_addr, bus.mem_func3}), 32'h0);
        rst = 1'b0;

        do_single(1'b1, 1'b0, 3'b010, 6'd4, 32'h0, "fetch_addr4");

        run_mix(1, 1'b0, 6'd56, 6'd8, "same_cycle");
        run_mix(3, 1'b1, 6'd40, 6'd12, "starve_stores");

        do_single(1'b0, 1'b0, 3'b001, 6'd53, 32'h0, "load_half_misaligned");
        do_single(1'b0, 1'b1, 3'b011, 6'd52, 32'h1234_5678, "store_illegal_f3");
        do_single(1'b1, 1'b0, 3'b010, 6'd18, 32'h0, "fetch_addr18");

        // Reset in the middle of a store's ACCESS cycle.
        wd = 32'hA5A5_1234;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_func3 = 3'b010;
        bus.dm_addr  = 6'd20;
        bus.dm_wdata = wd;
        tick();
        check("abort_write_before", 32'(bus.mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_write_async", 32'({bus.mem_write, bus.mem_read}), 32'd0);
        tick();
        check("abort_no_ready", 32'(bus.dm_ready), 32'd0);
        check("abort_mem_untouched", mem_arr[20], init_word(20));
        rst = 1'b0;
        tick();
        check("regrant_write", 32'(bus.mem_write), 32'd1);
        tick();
        check("regrant_ready", 32'(bus.dm_ready), 32'd1);
        bus.dm_req = 1'b0;
        check("regrant_mem", mem_arr[20], wd);
        tick();

        for (int i = 0; i < 30; i++) begin
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), a, $urandom, "rand_single");
        end

        for (int i = 0; i < 5; i++) begin
            a  = 6'($urandom_range(0, 7) * 4);
            fa = 6'($urandom_range(8, 15) * 4);
            run_mix(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), a, fa, "rand_mix");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
